// File: rtl/fft_inverse_butterfly.sv
// fft_inverse_butterfly: multicycle radix-2 inverse butterfly recovering A and B from P, N and W with one shared multiplier
module fft_inverse_butterfly #(
    parameter int DW   = 16,
    parameter int FRAC = 15
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2*DW-1:0] p_in,
    input  logic [2*DW-1:0] n_in,
    input  logic [2*DW-1:0] w_in,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [2*DW-1:0] a_out,
    output logic [2*DW-1:0] b_out,
    output logic            busy
);
    localparam int AW = 2*DW + 1;
    localparam logic signed [AW-1:0] SMAX = AW'(2**(DW-1) - 1);
    localparam logic signed [AW-1:0] SMIN = ~SMAX;

    typedef enum logic [2:0] {IDLE, M_RR, M_II, M_IR, M_RI, OUT} state_t;

    state_t                 state_q;
    logic signed [DW-1:0]   a_re_q, a_im_q, d_re_q, d_im_q, w_re_q, w_im_q, b_re_q;
    logic signed [AW-1:0]   acc_q, acc_d;
    logic signed [DW-1:0]   mul_a, mul_b;
    logic signed [2*DW-1:0] prod;
    logic signed [AW-1:0]   prod_x;
    logic [DW-1:0]          sat_v;

    function automatic logic signed [DW-1:0] half(input logic signed [DW-1:0] x, input logic signed [DW-1:0] y, input logic sub);
        logic signed [DW:0] s;
        s = sub ? (DW+1)'(x) - (DW+1)'(y) : (DW+1)'(x) + (DW+1)'(y);
        return DW'(s >>> 1);
    endfunction

    function automatic logic [DW-1:0] sat(input logic signed [AW-1:0] v);
        logic signed [AW-1:0] s;
        s = v >>> FRAC;
        return (s > SMAX) ? SMAX[DW-1:0] : (s < SMIN) ? SMIN[DW-1:0] : s[DW-1:0];
    endfunction

    assign in_ready  = rst_n && (state_q == IDLE);
    assign out_valid = (state_q == OUT);
    assign busy      = (state_q != IDLE);

    // operand muxes for the shared multiplier and the accumulate/subtract step
    always_comb begin
        mul_a  = (state_q == M_RR || state_q == M_RI) ? d_re_q : d_im_q;
        mul_b  = (state_q == M_RR || state_q == M_IR) ? w_re_q : w_im_q;
        prod   = (2*DW)'(mul_a) * (2*DW)'(mul_b);
        prod_x = AW'(prod);
        acc_d  = (state_q == M_RR || state_q == M_IR) ? prod_x :
                 (state_q == M_II) ? acc_q + prod_x :
                 (state_q == M_RI) ? acc_q - prod_x : acc_q;
        sat_v  = sat(acc_d);
    end

    // sequencer: capture on accept, four multiply steps, hold result until taken
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            a_out   <= '0;
            b_out   <= '0;
            a_re_q  <= '0;
            a_im_q  <= '0;
            d_re_q  <= '0;
            d_im_q  <= '0;
            w_re_q  <= '0;
            w_im_q  <= '0;
            b_re_q  <= '0;
        end else begin
            acc_q <= acc_d;
            case (state_q)
                IDLE: if (in_valid) begin
                    a_re_q  <= half(p_in[2*DW-1:DW], n_in[2*DW-1:DW], 1'b0);
                    a_im_q  <= half(p_in[DW-1:0], n_in[DW-1:0], 1'b0);
                    d_re_q  <= half(p_in[2*DW-1:DW], n_in[2*DW-1:DW], 1'b1);
                    d_im_q  <= half(p_in[DW-1:0], n_in[DW-1:0], 1'b1);
                    w_re_q  <= w_in[2*DW-1:DW];
                    w_im_q  <= w_in[DW-1:0];
                    state_q <= M_RR;
                end
                M_RR: state_q <= M_II;
                M_II: begin
                    b_re_q  <= sat_v;
                    state_q <= M_IR;
                end
                M_IR: state_q <= M_RI;
                M_RI: begin
                    a_out   <= {a_re_q, a_im_q};
                    b_out   <= {b_re_q, sat_v};
                    state_q <= OUT;
                end
                OUT: if (out_ready) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fft_inverse_butterfly.sv
// tb_fft_inverse_butterfly: scoreboard bench for the inverse butterfly
module tb_fft_inverse_butterfly;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [31:0] p_in = '0, n_in = '0, w_in = '0;
    logic        in_ready, out_valid, busy;
    logic [31:0] a_out, b_out;
    int          total = 0, bad = 0, cyc = 0, acc_cyc = 0;
    logic [63:0] sb[$];
    logic [63:0] sb_exp;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fft_inverse_butterfly dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .p_in(p_in), .n_in(n_in), .w_in(w_in), .out_valid(out_valid),
        .out_ready(out_ready), .a_out(a_out), .b_out(b_out), .busy(busy)
    );

    // scoreboard: every completed output handshake pops one expected result
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL scoreboard_unexpected got a=%h b=%h, none expected", a_out, b_out);
            end else begin
                sb_exp = sb.pop_front();
                if ({a_out, b_out} !== sb_exp) begin
                    bad++;
                    $display("FAIL scoreboard_result got a=%h b=%h want a=%h b=%h", a_out, b_out, sb_exp[63:32], sb_exp[31:0]);
                end
            end
        end
    end

    function automatic logic [15:0] sat16(input longint v);
        return (v > 32767) ? 16'h7FFF : (v < -32768) ? 16'h8000 : v[15:0];
    endfunction

    function automatic logic [63:0] inv_model(input logic [31:0] p, input logic [31:0] n, input logic [31:0] w);
        int pr = int'($signed(p[31:16]));
        int pi = int'($signed(p[15:0]));
        int nr = int'($signed(n[31:16]));
        int ni = int'($signed(n[15:0]));
        longint wr = longint'($signed(w[31:16]));
        longint wi = longint'($signed(w[15:0]));
        int ar = (pr + nr) >>> 1;
        int ai = (pi + ni) >>> 1;
        longint dr = longint'((pr - nr) >>> 1);
        longint di = longint'((pi - ni) >>> 1);
        longint br = (dr * wr + di * wi) >>> 15;
        longint bi = (di * wr - dr * wi) >>> 15;
        return {ar[15:0], ai[15:0], sat16(br), sat16(bi)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] p, input logic [31:0] n, input logic [31:0] w);
        int i = 0;
        p_in = p;
        n_in = n;
        w_in = w;
        in_valid = 1'b1;
        while (!in_ready && i < 20) begin
            tick();
            i++;
        end
        if (!in_ready) begin
            total++;
            bad++;
            $display("FAIL send_timeout in_ready=%b required 1", in_ready);
        end
        tick();
        acc_cyc = cyc;
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        if (!out_valid) begin
            total++;
            bad++;
            $display("FAIL out_timeout out_valid=%b required 1", out_valid);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got %b want 0", busy); end
        total++; if ({a_out, b_out} !== 64'h0) begin bad++; $display("FAIL reset_outputs got a=%h b=%h want 0", a_out, b_out); end
        rst_n = 1'b1;
        tick();
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_release_in_ready got %b want 1", in_ready); end
    endtask

    task automatic test_identity();
        int lat;
        sb.push_back({32'h0046_0014, 32'h001D_001D});
        send(32'h0064_0032, 32'h0028_FFF6, 32'h7FFF_0000);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL identity_busy got %b want 1", busy); end
        wait_out(lat);
        total++; if (lat != 4) begin bad++; $display("FAIL identity_latency got %0d want 4", lat); end
        tick();
    endtask

    task automatic test_imag();
        int lat;
        sb.push_back({32'h0046_0014, 32'h001D_FFE2});
        send(32'h0064_0032, 32'h0028_FFF6, 32'h0000_7FFF);
        wait_out(lat);
        total++; if (lat != 4) begin bad++; $display("FAIL imag_latency got %0d want 4", lat); end
        tick();
    endtask

    task automatic test_saturation();
        int lat;
        sb.push_back({32'hFFFF_FFFF, 32'h7FFF_0000});
        send(32'h8000_8000, 32'h7FFF_7FFF, 32'h8000_8000);
        wait_out(lat);
        tick();
        sb.push_back({32'hFFFF_FFFF, 32'h8000_0001});
        send(32'h7FFF_8000, 32'h8000_7FFF, 32'h8000_7FFF);
        wait_out(lat);
        tick();
    endtask

    task automatic test_backpressure();
        int lat;
        logic [63:0] held;
        out_ready = 1'b0;
        sb.push_back({32'h0046_0014, 32'h001D_001D});
        send(32'h0064_0032, 32'h0028_FFF6, 32'h7FFF_0000);
        wait_out(lat);
        held = {a_out, b_out};
        p_in = 32'h1234_0100;
        n_in = 32'h0200_F000;
        w_in = 32'h5A82_A57E;
        in_valid = 1'b1;
        repeat (3) begin
            tick();
            total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL stall_out_valid got %b want 1", out_valid); end
            total++; if ({a_out, b_out} !== held) begin bad++; $display("FAIL stall_outputs got %h want %h", {a_out, b_out}, held); end
            total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL stall_in_ready got %b want 0", in_ready); end
        end
        out_ready = 1'b1;
        sb.push_back(inv_model(32'h1234_0100, 32'h0200_F000, 32'h5A82_A57E));
        send(32'h1234_0100, 32'h0200_F000, 32'h5A82_A57E);
        wait_out(lat);
        total++; if (lat != 4) begin bad++; $display("FAIL stall_second_latency got %0d want 4", lat); end
        tick();
    endtask

    task automatic test_reset_mid();
        logic seen = 1'b0;
        send(32'h0064_0032, 32'h0028_FFF6, 32'h7FFF_0000);
        tick();
        rst_n = 1'b0;
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL midreset_out_valid got %b want 0", out_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL midreset_busy got %b want 0", busy); end
        total++; if ({a_out, b_out} !== 64'h0) begin bad++; $display("FAIL midreset_outputs got a=%h b=%h want 0", a_out, b_out); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL midreset_in_ready_low got %b want 0", in_ready); end
        rst_n = 1'b1;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL midreset_in_ready_release got %b want 1", in_ready); end
        repeat (10) begin
            tick();
            if (out_valid) seen = 1'b1;
        end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL midreset_aborted_output got %b want 0", seen); end
    endtask

    task automatic test_round_trip();
        int lat, er, ei;
        logic [31:0] a0 = 32'h0037_0021;
        logic [31:0] b0 = 32'h0001_004D;
        logic [31:0] w = 32'h5A82_5A82;
        longint ar = longint'($signed(a0[31:16]));
        longint ai = longint'($signed(a0[15:0]));
        longint br = longint'($signed(b0[31:16]));
        longint bi = longint'($signed(b0[15:0]));
        longint wr = longint'($signed(w[31:16]));
        longint wi = longint'($signed(w[15:0]));
        longint tr = (br * wr - bi * wi) >>> 15;
        longint ti = (br * wi + bi * wr) >>> 15;
        logic [31:0] p = {16'(ar + tr), 16'(ai + ti)};
        logic [31:0] n = {16'(ar - tr), 16'(ai - ti)};
        sb.push_back(inv_model(p, n, w));
        send(p, n, w);
        wait_out(lat);
        total++; if (a_out !== a0) begin bad++; $display("FAIL roundtrip_a got %h want %h", a_out, a0); end
        er = int'($signed(b_out[31:16])) - int'(br);
        ei = int'($signed(b_out[15:0])) - int'(bi);
        total++; if (er > 2 || er < -2) begin bad++; $display("FAIL roundtrip_b_re got %h want %h +-2", b_out[31:16], b0[31:16]); end
        total++; if (ei > 2 || ei < -2) begin bad++; $display("FAIL roundtrip_b_im got %h want %h +-2", b_out[15:0], b0[15:0]); end
        tick();
    endtask

    task automatic test_back_to_back();
        int lat;
        int prev = 0;
        logic [31:0] p, n, w;
        for (int k = 0; k < 6; k++) begin
            p = $urandom;
            n = $urandom;
            w = $urandom;
            sb.push_back(inv_model(p, n, w));
            send(p, n, w);
            if (k > 0) begin
                total++;
                if (acc_cyc - prev != 6) begin bad++; $display("FAIL b2b_interval got %0d want 6", acc_cyc - prev); end
            end
            prev = acc_cyc;
            wait_out(lat);
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_identity();
        test_imag();
        test_saturation();
        test_backpressure();
        test_reset_mid();
        test_round_trip();
        test_back_to_back();
        repeat (3) tick();
        total++;
        if (sb.size() != 0) begin bad++; $display("FAIL scoreboard_drain got %0d pending want 0", sb.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
